simon_sequence_player: RTL and testbench

- Output side of the Simon datapath: plays the stored colour sequence back to the player as timed LED flashes. The button path is the input side.
- On a start request it reads entries 0..len-1 from the sequence ROM. Each entry lights one LED for ON_TICKS ticks, then all LEDs go dark for OFF_TICKS ticks.
- Signals completion so the game FSM can enter the input-collection phase. Sits between sequence_rom and the LED mux in top.

---
 rtl/simon_sequence_player.sv | 165 ++++++++++++++++
 tb/tb_simon_sequence_player.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_player.sv
// simon_sequence_player
//   Plays the stored Simon colour sequence back as timed LED flashes.
//   Entry k of the sequence ROM lights LED rd_data for ON_TICKS tick pulses,
//   followed by a dark gap of OFF_TICKS tick pulses. A one-clk done pulse
//   marks normal completion so the game FSM can start collecting input.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   tick     single-cycle timing enable; timers only advance when high
//   start    playback request, honoured only while idle
//   len      number of entries to play (clamped to DEPTH), latched on start
//   abort    synchronous cancel; returns to idle with no done pulse
//   rd_addr  sequence ROM read address
//   rd_data  sequence ROM data, valid one clk after rd_addr changes
//   led      one-hot LED drive, zero while dark
//   busy     high from accepted start until back in idle
//   done     one-clk pulse on normal completion
//   step     index of the entry currently being played
module simon_sequence_player #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ON,
    S_OFF,
    S_FIN
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] len_q, len_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] idx_inc;
  logic [TW-1:0]     timer, timer_n;
  logic [1:0]        cur, cur_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      len_q  <= '0;
      addr_q <= '0;
      timer  <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      len_q  <= len_n;
      addr_q <= addr_n;
      timer  <= timer_n;
    end
  end

  // The captured colour only matters while lit, so it carries no reset.
  always_ff @(posedge clk) begin
    cur <= cur_n;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    addr_n  = addr_q;
    timer_n = timer;
    cur_n   = cur;
    idx_inc = idx + ADDR_W'(1);

    case (state)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          len_n   = (len > DEPTH_A) ? DEPTH_A : len;
          idx_n   = '0;
          addr_n  = '0;
          timer_n = '0;
          state_n = (len == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        // rd_addr is already stable; this cycle covers the ROM read latency
        state_n = S_LOAD;
      end
      S_LOAD: begin
        cur_n   = rd_data;
        timer_n = '0;
        state_n = S_ON;
      end
      S_ON: begin
        if (tick) begin
          if (timer == ON_LAST) begin
            timer_n = '0;
            state_n = S_OFF;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      S_OFF: begin
        if (tick) begin
          if (timer == OFF_LAST) begin
            timer_n = '0;
            // idx stays on the last entry at completion so step never
            // reaches len_q
            if (idx_inc == len_q) begin
              state_n = S_FIN;
            end else begin
              idx_n   = idx_inc;
              addr_n  = idx_inc;
              state_n = S_FETCH;
            end
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      timer_n = '0;
    end
  end

  // Outputs decode registered state only, so they are free of input paths.
  always_comb begin
    led     = (state == S_ON) ? (4'b0001 << cur) : 4'b0000;
    busy    = (state != S_IDLE);
    done    = (state == S_FIN);
    rd_addr = addr_q;
    step    = idx;
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
module tb_simon_sequence_player;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic [3:0] step;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] rom [16];

  simon_sequence_player #(
    .DEPTH(4), .ADDR_W(4), .ON_TICKS(8), .OFF_TICKS(4)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .len(len),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .led(led),
    .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  // synchronous-read sequence ROM
  always_ff @(posedge clk) rd_data <= rom[rd_addr];

  typedef struct {
    logic [3:0] len;
    int         period;   // 1: tick every clk; 10: tick in cycles with c%10==2
    int         total;    // cycle (after accepting edge) in which done is high
    int         flashes;
    int         first;    // length in clks of the first flash
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start a playback and follow it to one cycle past done. Cycle 1 is the
  // first cycle after the edge that accepts start.
  task automatic play(input string nm, input logic [3:0] l, input int p,
                      input int total, input int flashes, input int first,
                      input int restart_at);
    int lc, seq_err, done_err, busy_err, hot_err, nflash, flen, amax, i, r;
    logic [3:0] prev, el;
    lc = (l > 4'd4) ? 4 : int'(l);
    seq_err = 0; done_err = 0; busy_err = 0; hot_err = 0;
    nflash = 0; flen = 0; amax = 0; prev = 4'd0;
    @(negedge clk);
    len = l; start = 1'b1; abort = 1'b0; tick = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= total + 1; c++) begin
      if (c > 1) @(negedge clk);
      tick  = (p == 1) ? 1'b1 : ((c % p) == 2);
      start = (c == restart_at);
      if (start) len = 4'd1;
      if (done !== (c == total)) done_err++;
      if (busy !== (c <= total)) busy_err++;
      if ((led & (led - 4'd1)) != 4'd0) hot_err++;
      if (int'(rd_addr) > amax) amax = int'(rd_addr);
      if (led != 4'd0 && prev == 4'd0) nflash++;
      if (led != 4'd0 && nflash == 1) flen++;
      prev = led;
      if (p == 1) begin
        el = 4'd0;
        if (c <= 14 * lc) begin
          i = (c - 1) / 14;
          r = (c - 1) % 14;
          if (r >= 2 && r <= 9) el = 4'd1 << rom[i];
          if (rd_addr !== 4'(i) || step !== 4'(i)) seq_err++;
        end
        if (led !== el) seq_err++;
      end
    end
    start = 1'b0; tick = 1'b0;
    if (p == 1) check({nm, ".seq_errs"}, seq_err, 0);
    check({nm, ".done_errs"}, done_err, 0);
    check({nm, ".busy_errs"}, busy_err, 0);
    check({nm, ".onehot_errs"}, hot_err, 0);
    check({nm, ".flashes"}, nflash, flashes);
    check({nm, ".first_flash_len"}, flen, first);
    check({nm, ".addr_max"}, amax, (lc > 0) ? lc - 1 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int q, dcnt, b40, bz;
    logic [3:0] led_b, addr_b, step_b;

    tbl[0] = '{len: 4'd4, period: 1,  total: 57,  flashes: 4, first: 8};
    tbl[1] = '{len: 4'd0, period: 1,  total: 1,   flashes: 0, first: 0};
    tbl[2] = '{len: 4'd7, period: 1,  total: 57,  flashes: 4, first: 8};
    tbl[3] = '{len: 4'd1, period: 1,  total: 15,  flashes: 1, first: 8};
    tbl[4] = '{len: 4'd2, period: 1,  total: 29,  flashes: 2, first: 8};
    tbl[5] = '{len: 4'd1, period: 10, total: 123, flashes: 1, first: 80};

    for (int k = 0; k < 16; k++) rom[k] = 2'd0;
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1;

    clk = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0;
    len = 4'd0;
    repeat (3) @(negedge clk);
    check("reset.led", int'(led), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.rd_addr", int'(rd_addr), 0);
    check("reset.step", int'(step), 0);
    reset = 1'b0;

    // idle with tick toggling and no start
    q = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tick = c[0];
      if (led != 4'd0 || busy || done || rd_addr != 4'd0) q++;
    end
    tick = 1'b0;
    check("idle.quiet_errs", q, 0);

    for (int k = 0; k < 6; k++)
      play($sformatf("tbl%0d", k), tbl[k].len, tbl[k].period, tbl[k].total,
           tbl[k].flashes, tbl[k].first, 0);

    // second start during ON of entry 1 must be ignored
    play("restart", 4'd4, 1, 57, 4, 8, 20);

    // start and abort together while idle: abort wins
    @(negedge clk);
    len = 4'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    bz = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (busy || led != 4'd0) bz++;
    end
    check("start_abort.busy_errs", bz, 0);

    // abort during OFF of entry 2 (cycle 40)
    @(negedge clk);
    len = 4'd4; start = 1'b1; tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; b40 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      abort = (c == 40);
      if (done) dcnt++;
      if (c == 40) b40 = int'(busy);
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy_before", b40, 1);
    check("abort.led", int'(led), 0);
    check("abort.busy", int'(busy), 0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (done) dcnt++;
    end
    tick = 1'b0;
    check("abort.done_pulses", dcnt, 0);
    play("replay", 4'd4, 1, 57, 4, 8, 0);

    // reset mid-ON of entry 1 with a tick every 10 clks
    @(negedge clk);
    len = 4'd4; start = 1'b1; tick = 1'b0;
    @(negedge clk);
    start = 1'b0;
    led_b = 4'd0; addr_b = 4'd0; step_b = 4'd0;
    for (int c = 1; c <= 150; c++) begin
      if (c > 1) @(negedge clk);
      tick  = ((c % 10) == 2);
      reset = (c == 150);
      if (c == 149) begin
        led_b = led; addr_b = rd_addr; step_b = step;
      end
    end
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    check("midreset.led_before", int'(led_b), 1);
    check("midreset.addr_before", int'(addr_b), 1);
    check("midreset.step_before", int'(step_b), 1);
    check("midreset.led", int'(led), 0);
    check("midreset.busy", int'(busy), 0);
    check("midreset.done", int'(done), 0);
    check("midreset.rd_addr", int'(rd_addr), 0);
    check("midreset.step", int'(step), 0);
    play("after_reset", 4'd1, 10, 123, 1, 80, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
